defl_port_alloc: RTL



---
 rtl/minbd_pkg.sv | 31 +++
 rtl/golden_epoch_ctr.sv | 33 +++
 rtl/defl_port_alloc.sv | 97 +++++++++
 3 files changed

// File: rtl/minbd_pkg.sv
// Shared MinBD router types: direction indices, port vectors, flit ids,
// plus the single-flit port pick used by the deflection allocator.
package minbd_pkg;

  localparam int NUM_DIR   = 5;
  localparam int DIR_N     = 0;
  localparam int DIR_E     = 1;
  localparam int DIR_S     = 2;
  localparam int DIR_W     = 3;
  localparam int DIR_L     = 4;
  localparam int FLIT_ID_W = 6;

  typedef logic [NUM_DIR-1:0]   port_vec_t;
  typedef logic [FLIT_ID_W-1:0] flit_id_t;

  function automatic port_vec_t lowest_bit(input port_vec_t v);
    return v & (~v + port_vec_t'(1));
  endfunction

  // Productive port if one is free, else the lowest free network port.
  // Local is never offered as a deflection target.
  function automatic port_vec_t pick_port(input port_vec_t pref, input port_vec_t free);
    port_vec_t cand;
    port_vec_t net_free;
    cand     = pref & free;
    net_free = free & ~(port_vec_t'(1) << DIR_L);
    if (|cand) return lowest_bit(cand);
    else       return lowest_bit(net_free);
  endfunction

endpackage

// File: rtl/golden_epoch_ctr.sv
// Golden epoch counter: advances golden_id once every EPOCH_LEN cycles,
// wrapping golden_id at NUM_NODES.
module golden_epoch_ctr #(
  parameter int WIDTH_ID  = 6,
  parameter int EPOCH_LEN = 64,
  parameter int NUM_NODES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [WIDTH_ID-1:0] golden_id
);

  localparam int EW = $clog2(EPOCH_LEN);

  logic [EW-1:0] epoch_cnt;
  logic          epoch_wrap;

  assign epoch_wrap = (epoch_cnt == EW'(EPOCH_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt <= '0;
      golden_id <= '0;
    end else begin
      epoch_cnt <= epoch_wrap ? '0 : epoch_cnt + EW'(1);
      if (epoch_wrap) begin
        if (golden_id == WIDTH_ID'(NUM_NODES - 1)) golden_id <= '0;
        else                                       golden_id <= golden_id + WIDTH_ID'(1);
      end
    end
  end

endmodule

// File: rtl/defl_port_alloc.sv
// MinBD registered output-port allocator (golden + rotating silver priority).
// Optional deflection statistics counter: DEFL_PORT_ALLOC_STATS_EN.
module defl_port_alloc
  import minbd_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int WIDTH_ID  = 6,
  parameter int EPOCH_LEN = 64,
  parameter int NUM_NODES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_IN-1:0]                in_valid,
  input  logic [NUM_IN-1:0][NUM_DIR-1:0]   in_pref,
  input  logic [NUM_IN-1:0][WIDTH_ID-1:0]  in_id,
  output logic [NUM_IN-1:0]                alloc_valid,
  output logic [NUM_IN-1:0][NUM_DIR-1:0]   alloc_port,
  output logic [NUM_IN-1:0]                alloc_defl,
  output logic [WIDTH_ID-1:0]              golden_id
`ifdef DEFL_PORT_ALLOC_STATS_EN
  ,
  output logic [15:0]                      defl_count
`endif
);

  logic [1:0]                      silver_ptr;
  logic [NUM_IN-1:0][NUM_DIR-1:0]  grant;
  logic [NUM_IN-1:0]               defl_d;

  golden_epoch_ctr #(
    .WIDTH_ID  (WIDTH_ID),
    .EPOCH_LEN (EPOCH_LEN),
    .NUM_NODES (NUM_NODES)
  ) u_epoch (
    .clk       (clk),
    .rst_n     (rst_n),
    .golden_id (golden_id)
  );

  // Golden flits claim ports first in index order, then the rest in
  // rotating order from the silver pointer.
  always_comb begin
    port_vec_t  free;
    port_vec_t  g;
    logic [1:0] idx;
    free   = '1;
    g      = '0;
    idx    = '0;
    grant  = '0;
    defl_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i] && (in_id[i] == golden_id)) begin
        g        = pick_port(in_pref[i], free);
        grant[i] = g;
        free     = free & ~g;
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      idx = silver_ptr + 2'(k);
      if (in_valid[idx] && (in_id[idx] != golden_id)) begin
        g          = pick_port(in_pref[idx], free);
        grant[idx] = g;
        free       = free & ~g;
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      defl_d[i] = in_valid[i] & ~|(grant[i] & in_pref[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      silver_ptr  <= '0;
      alloc_valid <= '0;
      alloc_port  <= '0;
      alloc_defl  <= '0;
    end else begin
      silver_ptr  <= silver_ptr + 2'd1;
      alloc_valid <= in_valid;
      alloc_port  <= grant;
      alloc_defl  <= defl_d;
    end
  end

`ifdef DEFL_PORT_ALLOC_STATS_EN
  logic [16:0] defl_sum;

  assign defl_sum = {1'b0, defl_count} + 17'($countones(alloc_defl));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            defl_count <= '0;
    else if (defl_sum[16]) defl_count <= 16'hFFFF;
    else                   defl_count <= defl_sum[15:0];
  end
`endif

endmodule
